pe_array_stu_mux: RTL and testbench

Parametrised upstream aggregator for the PE array. It merges NUM_PE per-PE stack-upstream streams into one stack-upstream bus toward the stack. Arbitration is round-robin at packet granularity: once a PE wins, it holds the bus until its EOM beat. The block sits between the generated PE instances and the stack-upstream interface, replacing the per-PE fan-out of upstream wires. It adds packet locking, protocol-error detection and a packet counter.

---
 rtl/pe_array_pkg.sv | 24 ++
 rtl/pe_array_rr_arb.sv | 50 +++++
 rtl/pe_array_stu_mux.sv | 181 ++++++++++++++++++
 tb/tb_pe_array_stu_mux.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared cntl encodings, arbiter FSM states and grant-width helper
// Revision: 1.0
`default_nettype none

package pe_array_pkg;

   localparam logic [1:0] CNTL_MOM     = 2'b00;
   localparam logic [1:0] CNTL_SOM     = 2'b01;
   localparam logic [1:0] CNTL_EOM     = 2'b10;
   localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   // Index width for n channels; never narrower than one bit.
   function automatic int grant_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pe_array_rr_arb.sv
// pe_array_rr_arb: combinational round-robin picker, search starts at rr_ptr+1
// Revision: 1.0
`default_nettype none

module pe_array_rr_arb
   import pe_array_pkg::*;
#(
   parameter int NUM_PE  = 64,
   parameter int GRANT_W = 6
) (
   input  logic [NUM_PE-1:0]  req,
   input  logic [GRANT_W-1:0] rr_ptr,
   output logic [NUM_PE-1:0]  grant,
   output logic [GRANT_W-1:0] idx,
   output logic               any
);

   logic [GRANT_W-1:0] lo_idx;
   logic [GRANT_W-1:0] hi_idx;
   logic               hi_found;

   // Lowest requester above rr_ptr wins; otherwise wrap to the lowest overall.
   always_comb begin
      lo_idx   = '0;
      hi_idx   = '0;
      hi_found = 1'b0;
      for (int c = NUM_PE - 1; c >= 0; c--) begin
         if (req[c]) begin
            lo_idx = GRANT_W'(c);
         end
         if (req[c] && (c > int'(rr_ptr))) begin
            hi_idx   = GRANT_W'(c);
            hi_found = 1'b1;
         end
      end
   end

   assign idx = hi_found ? hi_idx : lo_idx;
   assign any = |req;

   always_comb begin
      grant = '0;
      for (int c = 0; c < NUM_PE; c++) begin
         grant[c] = any && (int'(idx) == c);
      end
   end

endmodule

`default_nettype wire

// File: rtl/pe_array_stu_mux.sv
// pe_array_stu_mux: packet-locked round-robin merge of NUM_PE upstream streams
// Revision: 1.0
`default_nettype none

module pe_array_stu_mux
   import pe_array_pkg::*;
#(
   parameter int  NUM_PE  = 64,
   parameter int  DATA_W  = 64,
   parameter int  TYPE_W  = 2,
   parameter int  OOB_W   = 32,
   parameter int  CNT_W   = 16,
   localparam int GRANT_W = grant_w(NUM_PE)
) (
   input  logic                      clk,
   input  logic                      reset_poweron,
   input  logic [NUM_PE-1:0]         pe__stu__valid,
   input  logic [2*NUM_PE-1:0]       pe__stu__cntl,
   input  logic [TYPE_W*NUM_PE-1:0]  pe__stu__type,
   input  logic [DATA_W*NUM_PE-1:0]  pe__stu__data,
   input  logic [OOB_W*NUM_PE-1:0]   pe__stu__oob_data,
   output logic [NUM_PE-1:0]         stu__pe__ready,
   output logic                      pe_array__stu__valid,
   output logic [1:0]                pe_array__stu__cntl,
   output logic [TYPE_W-1:0]         pe_array__stu__type,
   output logic [DATA_W-1:0]         pe_array__stu__data,
   output logic [OOB_W-1:0]          pe_array__stu__oob_data,
   input  logic                      stu__pe_array__ready,
   output logic [GRANT_W-1:0]        pe_array__stu__src_id,
   output logic [NUM_PE-1:0]         pe_array__sys__proto_err,
   input  logic                      sys__pe_array__clr_err,
   output logic [CNT_W-1:0]          pe_array__sys__pkt_count
);

   state_t             state, next_state;
   logic [GRANT_W-1:0] rr_ptr, next_rr;
   logic [GRANT_W-1:0] lock_id, next_lock;

   logic [NUM_PE-1:0]  arb_grant;
   logic [GRANT_W-1:0] arb_idx;
   logic               arb_any;

   logic [NUM_PE-1:0]  lock_onehot;
   logic [NUM_PE-1:0]  cur_onehot;
   logic [GRANT_W-1:0] cur_ch;
   logic               ld;
   logic               xfer;
   logic [NUM_PE-1:0]  err_set;

   logic [1:0]         in_cntl;
   logic [TYPE_W-1:0]  in_type;
   logic [DATA_W-1:0]  in_data;
   logic [OOB_W-1:0]   in_oob;

   pe_array_rr_arb #(
      .NUM_PE  (NUM_PE),
      .GRANT_W (GRANT_W)
   ) u_arb (
      .req    (pe__stu__valid),
      .rr_ptr (rr_ptr),
      .grant  (arb_grant),
      .idx    (arb_idx),
      .any    (arb_any)
   );

   always_comb begin
      lock_onehot = '0;
      for (int c = 0; c < NUM_PE; c++) begin
         lock_onehot[c] = (int'(lock_id) == c);
      end
   end

   assign ld             = ~pe_array__stu__valid | stu__pe_array__ready;
   assign cur_onehot     = (state == ST_LOCK) ? lock_onehot : arb_grant;
   assign cur_ch         = (state == ST_LOCK) ? lock_id : arb_idx;
   assign stu__pe__ready = cur_onehot & {NUM_PE{ld}};
   assign xfer           = |(pe__stu__valid & stu__pe__ready);

   // One-hot mux keeps data/type/oob off any index arithmetic path.
   always_comb begin
      in_cntl = '0;
      in_type = '0;
      in_data = '0;
      in_oob  = '0;
      for (int c = 0; c < NUM_PE; c++) begin
         if (cur_onehot[c]) begin
            in_cntl = pe__stu__cntl[2*c +: 2];
            in_type = pe__stu__type[TYPE_W*c +: TYPE_W];
            in_data = pe__stu__data[DATA_W*c +: DATA_W];
            in_oob  = pe__stu__oob_data[OOB_W*c +: OOB_W];
         end
      end
   end

   always_comb begin
      next_state = state;
      next_rr    = rr_ptr;
      next_lock  = lock_id;
      err_set    = '0;
      if (xfer) begin
         case (state)
            ST_IDLE: begin
               if (in_cntl == CNTL_SOM) begin
                  next_state = ST_LOCK;
                  next_lock  = cur_ch;
               end else begin
                  // Stray MOM/EOM is closed out as a one-beat packet.
                  next_rr = cur_ch;
                  if (in_cntl != CNTL_SOM_EOM) begin
                     err_set = cur_onehot;
                  end
               end
            end
            ST_LOCK: begin
               if (in_cntl == CNTL_SOM || in_cntl == CNTL_SOM_EOM) begin
                  err_set = cur_onehot;
               end
               if (in_cntl[1]) begin
                  next_state = ST_IDLE;
                  next_rr    = lock_id;
               end
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         state   <= ST_IDLE;
         rr_ptr  <= GRANT_W'(NUM_PE - 1);
         lock_id <= '0;
      end else begin
         state   <= next_state;
         rr_ptr  <= next_rr;
         lock_id <= next_lock;
      end
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         pe_array__stu__valid    <= 1'b0;
         pe_array__stu__cntl     <= '0;
         pe_array__stu__type     <= '0;
         pe_array__stu__data     <= '0;
         pe_array__stu__oob_data <= '0;
         pe_array__stu__src_id   <= '0;
      end else if (ld) begin
         pe_array__stu__valid <= xfer;
         if (xfer) begin
            pe_array__stu__cntl     <= in_cntl;
            pe_array__stu__type     <= in_type;
            pe_array__stu__data     <= in_data;
            pe_array__stu__oob_data <= in_oob;
            pe_array__stu__src_id   <= cur_ch;
         end
      end
   end

   // A fresh error in the clearing cycle survives the clear.
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         pe_array__sys__proto_err <= '0;
      end else begin
         pe_array__sys__proto_err <= (sys__pe_array__clr_err ? '0 : pe_array__sys__proto_err)
                                     | err_set;
      end
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         pe_array__sys__pkt_count <= '0;
      end else if (pe_array__stu__valid && stu__pe_array__ready && pe_array__stu__cntl[1]
                   && (pe_array__sys__pkt_count != '1)) begin
         pe_array__sys__pkt_count <= pe_array__sys__pkt_count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pe_array_stu_mux.sv
// tb_pe_array_stu_mux: directed self-checking bench, 8 channels, 4-bit packet counter
// Revision: 1.0
`default_nettype none

module tb_pe_array_stu_mux;

   localparam int NPE = 8;
   localparam int DW  = 16;
   localparam int TW  = 2;
   localparam int OW  = 8;
   localparam int CW  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NPE-1:0]    valid = '0;
   logic [2*NPE-1:0]  cntl = '0;
   logic [TW*NPE-1:0] typ = '0;
   logic [DW*NPE-1:0] data = '0;
   logic [OW*NPE-1:0] oob = '0;
   logic [NPE-1:0]    rdy;
   logic              o_valid;
   logic [1:0]        o_cntl;
   logic [TW-1:0]     o_type;
   logic [DW-1:0]     o_data;
   logic [OW-1:0]     o_oob;
   logic              ds_ready = 1'b0;
   logic [2:0]        src_id;
   logic [NPE-1:0]    proto_err;
   logic              clr_err = 1'b0;
   logic [CW-1:0]     pkt_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pe_array_stu_mux #(
      .NUM_PE (NPE), .DATA_W (DW), .TYPE_W (TW), .OOB_W (OW), .CNT_W (CW)
   ) dut (
      .clk                      (clk),
      .reset_poweron            (rst),
      .pe__stu__valid           (valid),
      .pe__stu__cntl            (cntl),
      .pe__stu__type            (typ),
      .pe__stu__data            (data),
      .pe__stu__oob_data        (oob),
      .stu__pe__ready           (rdy),
      .pe_array__stu__valid     (o_valid),
      .pe_array__stu__cntl      (o_cntl),
      .pe_array__stu__type      (o_type),
      .pe_array__stu__data      (o_data),
      .pe_array__stu__oob_data  (o_oob),
      .stu__pe_array__ready     (ds_ready),
      .pe_array__stu__src_id    (src_id),
      .pe_array__sys__proto_err (proto_err),
      .sys__pe_array__clr_err   (clr_err),
      .pe_array__sys__pkt_count (pkt_count)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Beat payload: data = {channel, beat number}, type = channel[1:0], oob = A0+channel.
   task automatic set_ch(input int ch, input logic v, input logic [1:0] c, input logic [7:0] b);
      valid[ch]          = v;
      cntl[2*ch +: 2]    = c;
      data[DW*ch +: DW]  = {8'(ch), b};
      typ[TW*ch +: TW]   = 2'(ch);
      oob[OW*ch +: OW]   = 8'hA0 + 8'(ch);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      n_checks++; if ({o_cntl, o_type, o_data, o_oob, src_id} !== '0) begin n_fail++;
         $display("FAIL reset_outs: got %h want 0", {o_cntl, o_type, o_data, o_oob, src_id}); end
      n_checks++; if (pkt_count !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", pkt_count); end
      n_checks++; if (proto_err !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %h want 00", proto_err); end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int order[3] = '{0, 1, 3};
      ds_ready = 1'b1;
      set_ch(0, 1'b1, 2'b11, 8'd0);
      set_ch(1, 1'b1, 2'b11, 8'd0);
      set_ch(3, 1'b1, 2'b11, 8'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (rdy !== 8'(1 << order[i])) begin n_fail++;
            $display("FAIL basic_ready%0d: got %h want %h", i, rdy, 8'(1 << order[i])); end
         step();
         n_checks++; if (o_valid !== 1'b1 || src_id !== 3'(order[i]) || o_cntl !== 2'b11
                         || o_data !== {8'(order[i]), 8'd0}) begin n_fail++;
            $display("FAIL basic_out%0d: got v=%b src=%0d cntl=%b data=%h want v=1 src=%0d cntl=11 data=%h",
                     i, o_valid, src_id, o_cntl, o_data, order[i], {8'(order[i]), 8'd0}); end
         set_ch(order[i], 1'b0, 2'b00, 8'd0);
      end
      n_checks++; if (o_type !== 2'd3 || o_oob !== 8'hA3) begin n_fail++;
         $display("FAIL basic_side: got type=%0d oob=%h want 3 a3", o_type, o_oob); end
      step();
      n_checks++; if (o_valid !== 1'b0 || pkt_count !== 4'd3) begin n_fail++;
         $display("FAIL basic_cnt: got v=%b cnt=%0d want v=0 cnt=3", o_valid, pkt_count); end
   endtask

   task automatic test_contention();
      logic [1:0] seq [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
      for (int b = 0; b < 4; b++) begin
         set_ch(2, 1'b1, seq[b], 8'(b));
         if (b == 1) set_ch(5, 1'b1, 2'b11, 8'd0);
         #1;
         n_checks++; if (rdy !== 8'h04) begin n_fail++;
            $display("FAIL cont_ready%0d: got %h want 04", b, rdy); end
         step();
         n_checks++; if (o_valid !== 1'b1 || src_id !== 3'd2 || o_cntl !== seq[b] || o_data !== {8'd2, 8'(b)}) begin
            n_fail++; $display("FAIL cont_out%0d: got src=%0d cntl=%b data=%h want src=2 cntl=%b data=%h",
                               b, src_id, o_cntl, o_data, seq[b], {8'd2, 8'(b)}); end
      end
      set_ch(2, 1'b0, 2'b00, 8'd0);
      #1;
      n_checks++; if (rdy !== 8'h20) begin n_fail++; $display("FAIL cont_ready_ch5: got %h want 20", rdy); end
      step();
      n_checks++; if (o_valid !== 1'b1 || src_id !== 3'd5 || o_cntl !== 2'b11) begin n_fail++;
         $display("FAIL cont_ch5: got v=%b src=%0d cntl=%b want 1 5 11", o_valid, src_id, o_cntl); end
      set_ch(5, 1'b0, 2'b00, 8'd0);
      step();
      n_checks++; if (o_valid !== 1'b0 || pkt_count !== 4'd5) begin n_fail++;
         $display("FAIL cont_cnt: got v=%b cnt=%0d want 0 5", o_valid, pkt_count); end
   endtask

   task automatic test_backpressure();
      logic [1:0] seq  [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
      logic       ds   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int         expb [6] = '{0, 0, 0, 1, 2, 3};
      int b = 0;
      for (int i = 0; i < 6; i++) begin
         set_ch(1, 1'b1, seq[b], 8'(b));
         ds_ready = ds[i];
         #1;
         n_checks++; if (rdy !== (ds[i] ? 8'h02 : 8'h00)) begin n_fail++;
            $display("FAIL bp_ready%0d: got %h want %h", i, rdy, ds[i] ? 8'h02 : 8'h00); end
         step();
         if (ds[i]) b++;
         n_checks++; if (o_valid !== 1'b1 || o_data !== {8'd1, 8'(expb[i])} || o_cntl !== seq[expb[i]]) begin
            n_fail++; $display("FAIL bp_out%0d: got v=%b data=%h cntl=%b want v=1 data=%h cntl=%b",
                               i, o_valid, o_data, o_cntl, {8'd1, 8'(expb[i])}, seq[expb[i]]); end
      end
      set_ch(1, 1'b0, 2'b00, 8'd0);
      ds_ready = 1'b1;
      step();
      n_checks++; if (o_valid !== 1'b0 || pkt_count !== 4'd6) begin n_fail++;
         $display("FAIL bp_cnt: got v=%b cnt=%0d want 0 6", o_valid, pkt_count); end
   endtask

   task automatic test_proto_err();
      set_ch(4, 1'b1, 2'b00, 8'd9);
      #1;
      n_checks++; if (rdy !== 8'h10) begin n_fail++; $display("FAIL perr_ready: got %h want 10", rdy); end
      step();
      n_checks++; if (o_valid !== 1'b1 || src_id !== 3'd4 || o_cntl !== 2'b00 || o_data !== 16'h0409) begin
         n_fail++; $display("FAIL perr_fwd: got v=%b src=%0d cntl=%b data=%h want 1 4 00 0409",
                            o_valid, src_id, o_cntl, o_data); end
      n_checks++; if (proto_err !== 8'h10) begin n_fail++; $display("FAIL perr_flag: got %h want 10", proto_err); end
      set_ch(4, 1'b0, 2'b00, 8'd0);
      set_ch(6, 1'b1, 2'b11, 8'd0);
      #1;
      n_checks++; if (rdy !== 8'h40) begin n_fail++; $display("FAIL perr_idle: got %h want 40", rdy); end
      step();
      set_ch(6, 1'b0, 2'b00, 8'd0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_checks++; if (proto_err !== 8'h00) begin n_fail++; $display("FAIL perr_clr: got %h want 00", proto_err); end
      n_checks++; if (pkt_count !== 4'd7) begin n_fail++; $display("FAIL perr_cnt: got %0d want 7", pkt_count); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] seq [3] = '{2'b01, 2'b00, 2'b00};
      for (int b = 0; b < 3; b++) begin
         set_ch(7, 1'b1, seq[b], 8'(b));
         step();
      end
      n_checks++; if (o_valid !== 1'b1 || src_id !== 3'd7) begin n_fail++;
         $display("FAIL rmid_pre: got v=%b src=%0d want 1 7", o_valid, src_id); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if ({o_valid, o_cntl, o_type, o_data, o_oob, src_id, pkt_count} !== '0) begin n_fail++;
         $display("FAIL rmid_async: got %h want 0", {o_valid, o_cntl, o_type, o_data, o_oob, src_id, pkt_count}); end
      set_ch(7, 1'b0, 2'b00, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      set_ch(0, 1'b1, 2'b11, 8'd0);
      set_ch(7, 1'b1, 2'b11, 8'd0);
      #1;
      n_checks++; if (rdy !== 8'h01) begin n_fail++; $display("FAIL rmid_prio: got %h want 01", rdy); end
      step();
      n_checks++; if (src_id !== 3'd0 || o_valid !== 1'b1) begin n_fail++;
         $display("FAIL rmid_src: got v=%b src=%0d want 1 0", o_valid, src_id); end
      set_ch(0, 1'b0, 2'b00, 8'd0);
      set_ch(7, 1'b0, 2'b00, 8'd0);
      step();
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ds_ready = 1'b1;
      set_ch(3, 1'b1, 2'b11, 8'd0);
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 15) begin
            n_checks++; if (pkt_count !== 4'd15) begin n_fail++;
               $display("FAIL sat_at15: got %0d want 15", pkt_count); end
         end
      end
      set_ch(3, 1'b0, 2'b00, 8'd0);
      step();
      n_checks++; if (pkt_count !== 4'd15) begin n_fail++; $display("FAIL sat_final: got %0d want 15", pkt_count); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_contention();
      test_backpressure();
      test_proto_err();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
